// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Pipeline front end. Holds the PC, issues in-order word fetches
//               and buffers returned instructions with their PCs for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] c_depth = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;
    logic [PW-1:0] r_fifo_wr;
    logic [PW-1:0] r_fifo_rd;
    logic [31:0]   r_pcq       [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]   r_fifo_data [FIFO_DEPTH];

    logic          w_credit;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_fire_ext;
    logic [CW-1:0] w_rsp_ext;
    logic [CW-1:0] w_push_ext;
    logic [CW-1:0] w_pop_ext;

    // Credit covers both buffered and in-flight (including stale) fetches,
    // so every response is guaranteed a free FIFO slot.
    assign w_credit       = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_depth;
    assign imem_req_valid = !rst && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_push = !rst && imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop  = inst_valid && inst_ready && !redirect_valid;

    assign w_fire_ext = {{(CW-1){1'b0}}, w_req_fire};
    assign w_rsp_ext  = {{(CW-1){1'b0}}, imem_rsp_valid};
    assign w_push_ext = {{(CW-1){1'b0}}, w_push};
    assign w_pop_ext  = {{(CW-1){1'b0}}, w_pop};

    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_fifo_data[r_fifo_rd] : 32'h0;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_fifo_rd]   : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
        end else begin
            r_outstanding <= r_outstanding + w_fire_ext - w_rsp_ext;
            if (w_req_fire)
                r_pcq_wr <= r_pcq_wr + 1'b1;
            // PC queue tracks every response, stale ones included
            if (imem_rsp_valid)
                r_pcq_rd <= r_pcq_rd + 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                r_drop_cnt <= r_outstanding - w_rsp_ext;
                r_fifo_rd  <= r_fifo_wr;
                r_count    <= '0;
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (imem_rsp_valid && (r_drop_cnt != '0))
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                if (w_push)
                    r_fifo_wr <= r_fifo_wr + 1'b1;
                if (w_pop)
                    r_fifo_rd <= r_fifo_rd + 1'b1;
                r_count <= r_count + w_push_ext - w_pop_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire)
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        if (w_push) begin
            r_fifo_pc[r_fifo_wr]   <= r_pcq[r_pcq_rd];
            r_fifo_data[r_fifo_wr] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Scoreboard bench for inst_fetch_unit with an in-order memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;

    logic        mem_hold = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] exp_q[$];
    int          pop_cyc[$];
    int          fires = 0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          base;

    inst_fetch_unit #(.RESET_PC(32'h0000_3000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory: accepted addresses queue up, answered in order one per cycle
    always @(negedge clk) begin
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            fires++;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
        end else if (!mem_hold && pend.size() > 0) begin
            imem_rsp_data  = memword(pend.pop_front());
            imem_rsp_valid = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    // Monitor: every instruction taken by decode must match the queue head
    always @(negedge clk) begin
        if (!rst && !redirect_valid && inst_valid && inst_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e);
                chk("inst", inst, memword(e));
            end
        end
    end

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_drain(input int maxcyc, input bit keep_ready);
        int k;
        for (k = 0; k < maxcyc; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        if (!keep_ready) inst_ready = 1'b0;
        if (k == maxcyc) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input bit check);
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0;
        imem_req_ready = 1'b0; mem_hold = 1'b0;
        @(posedge clk); #1;
        if (check) begin
            @(negedge clk);
            chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
            chk("rst_req_addr", imem_req_addr, 32'h3000);
            chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
            chk("rst_inst", inst, 32'h0);
            chk("rst_inst_pc", inst_pc, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        base = fires;
    endtask

    initial begin
        // 1: streaming at one instruction per cycle
        do_reset(1'b1);
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        pop_cyc.delete();
        expect_seq(32'h3000, 12);
        wait_drain(100, 1'b0);
        if (pop_cyc.size() >= 12)
            chk("throughput_span", 32'(pop_cyc[11] - pop_cyc[0]), 32'd11);
        else
            chk("throughput_pops", 32'(pop_cyc.size()), 32'd12);

        // 2: decode stalled from reset, credit limits fetches to four
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_inst_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_inst_pc", inst_pc, 32'h3000);
            chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
        end
        chk("stall_fires", 32'(fires - base), 32'd4);
        @(posedge clk); #1;
        expect_seq(32'h3000, 4);
        inst_ready = 1'b1;
        wait_drain(40, 1'b0);

        // 3: redirect with 3008/300C still in flight
        do_reset(1'b0);
        mem_hold = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("inflight_fires", 32'(fires - base), 32'd4);
        imem_req_ready = 1'b0;
        expect_seq(32'h3000, 2);
        mem_hold = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_hold = 1'b1;
        wait_drain(40, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        @(negedge clk);
        chk("redir_no_req", {31'h0, imem_req_valid}, 32'h0);
        @(posedge clk); #1;
        redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_hold = 1'b0; inst_ready = 1'b1;
        expect_seq(32'h3100, 3);
        wait_drain(40, 1'b0);

        // 4: memory stall holds the request steady
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mstall_req_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("mstall_req_addr", imem_req_addr, 32'h3004);
        end
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("mstall_fires", 32'(fires - base), 32'd2);
        expect_seq(32'h3000, 2);
        inst_ready = 1'b1;
        wait_drain(40, 1'b0);

        // 5: misaligned redirect coinciding with a response and a pop
        do_reset(1'b0);
        imem_req_ready = 1'b1; inst_ready = 1'b1;
        expect_seq(32'h3000, 5);
        wait_drain(40, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h3102;
        @(negedge clk);
        chk("redir5_inst_valid", {31'h0, inst_valid}, 32'h1);
        chk("redir5_no_req", {31'h0, imem_req_valid}, 32'h0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir5_flushed", {31'h0, inst_valid}, 32'h0);
        chk("redir5_req_addr", imem_req_addr, 32'h3100);
        chk("redir5_req_valid", {31'h0, imem_req_valid}, 32'h1);
        expect_seq(32'h3100, 2);
        wait_drain(40, 1'b0);

        // 6: reset mid-stream with the buffer full
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("full_inst_valid", {31'h0, inst_valid}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("midrst_req_addr", imem_req_addr, 32'h3000);
        expect_seq(32'h3000, 4);
        inst_ready = 1'b1;
        wait_drain(40, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
